mips_decode_q: RTL and testbench

MIPS_DECODE_Q -- requirements
Module: mips_decode_q

---
 rtl/mips_decode_q.sv | 192 +++++++++++++++++++
 tb/tb_mips_decode_q.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_q.sv
// Decoding instruction queue: MIPS words are decoded on entry and the 16-bit control
// bundle is buffered in a DEPTH-entry FIFO. Optional feature: MIPS_DECODE_ADDM_EN.
module mips_decode_q #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     zero,
  input  logic                     flush,
  output logic [2:0]               alu_op,
  output logic                     writeenable,
  output logic                     rd_src,
  output logic                     alu_src2,
  output logic                     except,
  output logic                     mem_read,
  output logic                     word_we,
  output logic                     byte_we,
  output logic                     byte_load,
  output logic                     lui,
  output logic                     slt,
  output logic                     addm,
  output logic [1:0]               control_type,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_BEQ  = 2'd1,
    KIND_J    = 2'd2,
    KIND_JR   = 2'd3
  } flow_kind_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       writeenable;
    logic       rd_src;
    logic       alu_src2;
    logic       except;
    logic       mem_read;
    logic       word_we;
    logic       byte_we;
    logic       byte_load;
    logic       lui;
    logic       slt;
    logic       addm;
    flow_kind_t kind;
  } bundle_t;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_inst_bits;
  bundle_t    dec;
  bundle_t    head;
  bundle_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic       push;
  logic       pop;

  assign opcode           = inst[31:26];
  assign funct            = inst[5:0];
  assign unused_inst_bits = ^inst[25:6];

  // Instruction decode; anything not recognised becomes an exception with no side effects.
  // NOTE: every field gets a default before the case, so no path can infer a latch.
  always_comb begin
    dec      = '0;
    dec.kind = KIND_NONE;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec.alu_op = 3'd2; dec.writeenable = 1'b1; dec.rd_src = 1'b1; end
          6'h22: begin dec.alu_op = 3'd3; dec.writeenable = 1'b1; dec.rd_src = 1'b1; end
          6'h24: begin dec.alu_op = 3'd4; dec.writeenable = 1'b1; dec.rd_src = 1'b1; end
          6'h25: begin dec.alu_op = 3'd5; dec.writeenable = 1'b1; dec.rd_src = 1'b1; end
          6'h26: begin dec.alu_op = 3'd7; dec.writeenable = 1'b1; dec.rd_src = 1'b1; end
          6'h27: begin dec.alu_op = 3'd6; dec.writeenable = 1'b1; dec.rd_src = 1'b1; end
          6'h2a: begin
            dec.alu_op      = 3'd3;
            dec.writeenable = 1'b1;
            dec.rd_src      = 1'b1;
            dec.slt         = 1'b1;
          end
          6'h08: dec.kind = KIND_JR;
`ifdef MIPS_DECODE_ADDM_EN
          6'h2c: begin
            dec.alu_op      = 3'd2;
            dec.writeenable = 1'b1;
            dec.rd_src      = 1'b1;
            dec.mem_read    = 1'b1;
            dec.addm        = 1'b1;
          end
`endif
          default: dec.except = 1'b1;
        endcase
      end
      6'h08: begin dec.alu_op = 3'd2; dec.writeenable = 1'b1; dec.alu_src2 = 1'b1; end
      6'h0c: begin dec.alu_op = 3'd4; dec.writeenable = 1'b1; dec.alu_src2 = 1'b1; end
      6'h0d: begin dec.alu_op = 3'd5; dec.writeenable = 1'b1; dec.alu_src2 = 1'b1; end
      6'h0e: begin dec.alu_op = 3'd7; dec.writeenable = 1'b1; dec.alu_src2 = 1'b1; end
      6'h04: begin dec.alu_op = 3'd3; dec.kind = KIND_BEQ; end
      6'h02: dec.kind = KIND_J;
      6'h23: begin
        dec.alu_op      = 3'd2;
        dec.writeenable = 1'b1;
        dec.alu_src2    = 1'b1;
        dec.mem_read    = 1'b1;
      end
      6'h2b: begin dec.alu_op = 3'd2; dec.alu_src2 = 1'b1; dec.word_we = 1'b1; end
      6'h24: begin
        dec.alu_op      = 3'd2;
        dec.writeenable = 1'b1;
        dec.alu_src2    = 1'b1;
        dec.mem_read    = 1'b1;
        dec.byte_load   = 1'b1;
      end
      6'h28: begin dec.alu_op = 3'd2; dec.alu_src2 = 1'b1; dec.byte_we = 1'b1; end
      6'h0f: begin dec.writeenable = 1'b1; dec.alu_src2 = 1'b1; dec.lui = 1'b1; end
      default: dec.except = 1'b1;
    endcase
  end

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Pointers are AW bits wide and DEPTH is a power of two, so +1 wraps DEPTH-1 -> 0.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; stale entries are never visible because the head is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign alu_op      = head.alu_op;
  assign writeenable = head.writeenable;
  assign rd_src      = head.rd_src;
  assign alu_src2    = head.alu_src2;
  assign except      = head.except;
  assign mem_read    = head.mem_read;
  assign word_we     = head.word_we;
  assign byte_we     = head.byte_we;
  assign byte_load   = head.byte_load;
  assign lui         = head.lui;
  assign slt         = head.slt;
  assign addm        = head.addm;

  // Branch resolution uses the live zero flag, so it must stay combinational.
  always_comb begin
    control_type = 2'd0;
    case (head.kind)
      KIND_BEQ: control_type = zero ? 2'd1 : 2'd0;
      KIND_J:   control_type = 2'd2;
      KIND_JR:  control_type = 2'd3;
      default:  control_type = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_mips_decode_q.sv
// Self-checking bench for mips_decode_q: directed scenarios plus randomized traffic
// checked against a mnemonic-level queue model.
module tb_mips_decode_q;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic        out_valid;
  logic        out_ready;
  logic        zero;
  logic        flush;
  logic [2:0]  alu_op;
  logic        writeenable, rd_src, alu_src2, except, mem_read, word_we, byte_we;
  logic        byte_load, lui, slt, addm;
  logic [1:0]  control_type;
  logic [$clog2(DEPTH):0] count;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] model_q[$];

  mips_decode_q #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready), .zero(zero), .flush(flush),
    .alu_op(alu_op), .writeenable(writeenable), .rd_src(rd_src), .alu_src2(alu_src2),
    .except(except), .mem_read(mem_read), .word_we(word_we), .byte_we(byte_we),
    .byte_load(byte_load), .lui(lui), .slt(slt), .addm(addm),
    .control_type(control_type), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string mnem(logic [31:0] w);
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: return "add";
        6'h22: return "sub";
        6'h24: return "and";
        6'h25: return "or";
        6'h26: return "xor";
        6'h27: return "nor";
        6'h2a: return "slt";
        6'h08: return "jr";
        6'h2c: begin
`ifdef MIPS_DECODE_ADDM_EN
          return "addm";
`else
          return "ill";
`endif
        end
        default: return "ill";
      endcase
    end
    case (op)
      6'h08: return "addi";
      6'h0c: return "andi";
      6'h0d: return "ori";
      6'h0e: return "xori";
      6'h04: return "beq";
      6'h02: return "j";
      6'h23: return "lw";
      6'h2b: return "sw";
      6'h24: return "lbu";
      6'h28: return "sb";
      6'h0f: return "lui";
      default: return "ill";
    endcase
  endfunction

  // Flag letters: W writeenable, R rd_src, I alu_src2, X except, M mem_read, S word_we,
  // B byte_we, L byte_load, U lui, T slt, A addm.
  function automatic logic [13:0] pk(int alu, string flags);
    logic [13:0] v = '0;
    v[13:11] = alu[2:0];
    for (int i = 0; i < flags.len(); i++) begin
      case (flags[i])
        "W": v[10] = 1'b1;
        "R": v[9]  = 1'b1;
        "I": v[8]  = 1'b1;
        "X": v[7]  = 1'b1;
        "M": v[6]  = 1'b1;
        "S": v[5]  = 1'b1;
        "B": v[4]  = 1'b1;
        "L": v[3]  = 1'b1;
        "U": v[2]  = 1'b1;
        "T": v[1]  = 1'b1;
        "A": v[0]  = 1'b1;
        default: ;
      endcase
    end
    return v;
  endfunction

  function automatic logic [13:0] exp_ctrl(logic [31:0] w);
    case (mnem(w))
      "add":  return pk(2, "WR");
      "sub":  return pk(3, "WR");
      "and":  return pk(4, "WR");
      "or":   return pk(5, "WR");
      "xor":  return pk(7, "WR");
      "nor":  return pk(6, "WR");
      "slt":  return pk(3, "WRT");
      "jr":   return pk(0, "");
      "addi": return pk(2, "WI");
      "andi": return pk(4, "WI");
      "ori":  return pk(5, "WI");
      "xori": return pk(7, "WI");
      "beq":  return pk(3, "");
      "j":    return pk(0, "");
      "lw":   return pk(2, "WIM");
      "sw":   return pk(2, "IS");
      "lbu":  return pk(2, "WIML");
      "sb":   return pk(2, "IB");
      "lui":  return pk(0, "WIU");
      "addm": return pk(2, "WRMA");
      default: return pk(0, "X");
    endcase
  endfunction

  function automatic logic [1:0] exp_ct(logic [31:0] w, logic z);
    string m = mnem(w);
    if (m == "beq") return z ? 2'd1 : 2'd0;
    if (m == "j")   return 2'd2;
    if (m == "jr")  return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [5:0] rfn[9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h08, 6'h2c};
    logic [5:0] iop[11] = '{6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h04, 6'h02, 6'h23, 6'h2b,
                            6'h24, 6'h28, 6'h0f};
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 3))
      0: w[31:26] = 6'h00;
      1: begin w[31:26] = 6'h00; w[5:0] = rfn[$urandom_range(0, 8)]; end
      2: w[31:26] = iop[$urandom_range(0, 10)];
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_outputs(input string tag);
    logic [13:0] got_c;
    logic [13:0] exp_c = '0;
    logic [1:0]  exp_t = 2'd0;
    got_c = {alu_op, writeenable, rd_src, alu_src2, except, mem_read, word_we, byte_we,
             byte_load, lui, slt, addm};
    if (model_q.size() != 0) begin
      exp_c = exp_ctrl(model_q[0]);
      exp_t = exp_ct(model_q[0], zero);
    end
    check({tag, ".count"},     32'(count),        32'(model_q.size()));
    check({tag, ".in_ready"},  32'(in_ready),     32'(model_q.size() != DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid),    32'(model_q.size() != 0));
    check({tag, ".ctrl"},      32'(got_c),        32'(exp_c));
    check({tag, ".ctype"},     32'(control_type), 32'(exp_t));
  endtask

  // Called just after a rising edge: drive, check the current head, advance one clock.
  task automatic step(input string tag, input logic v, input logic [31:0] w,
                      input logic rdy, input logic z, input logic fl);
    bit do_push, do_pop;
    in_valid = v; inst = w; out_ready = rdy; zero = z; flush = fl;
    #2;
    check_outputs(tag);
    do_push = v && (model_q.size() < DEPTH) && !fl;
    do_pop  = rdy && (model_q.size() != 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(w);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; inst = '0; out_ready = 1'b0; zero = 1'b0; flush = 1'b0;
    #2;
    check_outputs("reset");
    #10 reset = 1'b1;
    @(posedge clk); #1;

    step("add_in",  1'b1, 32'h0085_1020, 1'b1, 1'b0, 1'b0);
    step("add_out", 1'b0, 32'h0,         1'b1, 1'b0, 1'b0);
    step("add_gone", 1'b0, 32'h0,        1'b1, 1'b0, 1'b0);

    step("beq_in",  1'b1, 32'h1085_0004, 1'b0, 1'b0, 1'b0);
    step("beq_z0",  1'b0, 32'h0,         1'b0, 1'b0, 1'b0);
    step("beq_z1",  1'b0, 32'h0,         1'b0, 1'b1, 1'b0);
    step("beq_pop", 1'b0, 32'h0,         1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) step("fill", 1'b1, rand_inst(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("wrap", 1'b1, rand_inst(), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, rand_inst(), 1'b0, 1'b0, 1'b0);
    step("flush",      1'b1, 32'h0085_1020, 1'b1, 1'b0, 1'b1);
    step("post_flush", 1'b0, 32'h0,         1'b0, 1'b0, 1'b0);

    step("ill_in",   1'b1, 32'hfc00_0000, 1'b0, 1'b0, 1'b0);
    step("addm_in",  1'b1, 32'h0085_102c, 1'b1, 1'b0, 1'b0);
    step("addm_out", 1'b0, 32'h0,         1'b1, 1'b0, 1'b0);
    step("addm_gone", 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);

    step("pre_rst", 1'b1, rand_inst(), 1'b0, 1'b0, 1'b0);
    step("pre_rst", 1'b1, rand_inst(), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    model_q.delete();
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    step("rst_first", 1'b1, 32'h0085_1020, 1'b0, 1'b0, 1'b0);
    step("rst_head",  1'b0, 32'h0,         1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), rand_inst(), ($urandom_range(0, 2) != 0),
           1'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
